serial_word_feeder: RTL and testbench
=====================================

# serial_word_feeder

Parallel-to-serial front end for the bit-stream pattern detectors in the FSM library. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `d_out`. The serial output drives the detector's `d_in`, and `bit_valid` qualifies each bit. Back-to-back words stream with no idle bit between them, so patterns that span word boundaries reach the detector intact.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low (rst=0 resets immediately).
- `word_in`  input  WIDTH  parallel word; sampled when `word_valid && word_ready`.
- `word_valid`  input  1  upstream offers `word_in`.
- `word_ready`  output  1  block can accept a word this cycle.
- `d_out`  output  1  serial bit to the detector's `d_in`.
- `bit_valid`  output  1  `d_out` carries a real data or parity bit this cycle.
- `frame_start`  output  1  high while `d_out` carries the first bit of a word.
- `busy`  output  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: shift register empty.
  - SHIFT: emitting data bits; bit counter `cnt` runs 0..WIDTH-1.
  - PAR: emitting the parity bit; present only with the macro.
- Handshake: a transfer occurs on a rising edge where `word_valid && word_ready`. `word_valid` may rise or fall freely; the block has no stall input.
- `word_ready` = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1 && no parity) || (state==PAR).
- IDLE + transfer → SHIFT, `cnt`=0, shift register loaded.
- IDLE without a transfer → stays in IDLE.
- SHIFT with `cnt`<WIDTH-1 → `cnt`+1, register shifts by one position per MSB_FIRST.
- SHIFT with `cnt`==WIDTH-1:
  - Parity enabled → PAR.
  - Otherwise, transfer → SHIFT with `cnt`=0 and the new word loaded.
  - Otherwise, no transfer → IDLE.
- PAR + transfer → SHIFT with the new word loaded; PAR without a transfer → IDLE.
- `d_out` is the register bit selected by MSB_FIRST in SHIFT, the parity bit in PAR, and 0 in IDLE.
- `bit_valid` is 1 in SHIFT and PAR, 0 in IDLE.
- `frame_start` = (state==SHIFT && cnt==0).
- `cnt` width is clog2(WIDTH); it never wraps past WIDTH-1.
- Reset mid-word: the partially shifted word is discarded, with no flush and no partial output.
- Reset values: `d_out`=0, `bit_valid`=0, `frame_start`=0, `busy`=0, `word_ready`=1 as soon as `rst` returns to 1; state=IDLE, `cnt`=0.

## Timing
- Latency: a word accepted at edge N presents its first bit on `d_out` after edge N and before edge N+1. The detector samples that bit at edge N+1.
- A word occupies WIDTH cycles, or WIDTH+1 with parity.
- Sustained throughput is one bit per clock; a continuously valid upstream produces zero gap cycles.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- `word_ready` depends only on state, so there is no valid→ready combinational loop.
- Reset assertion is asynchronous; deassertion takes effect at the next edge. The bench releases `rst` away from the clock edge.

## Configuration
- `SERIAL_FEEDER_PARITY_EN` defined:
  - PAR state exists.
  - After each word's WIDTH data bits, one even-parity bit (XOR of the word) is emitted with `bit_valid`=1.
  - `word_ready` in the last data-bit cycle is 0.
- Not defined:
  - No PAR state and no parity logic.
  - The last data-bit cycle asserts `word_ready` for seamless streaming.

## Test plan
- Reset behaviour: hold `rst`=0 for 2 cycles → all outputs are reset values, `word_ready`=1. Then assert `rst`=0 mid-word → `bit_valid` drops to 0 immediately, without waiting for a clock edge.
- MSB-first single word: WIDTH=8, MSB_FIRST=1, `word_in`=8'hB0 → `d_out` sequence 1,0,1,1,0,0,0,0 with `bit_valid`=1 for 8 cycles, `frame_start` on the first bit only, then IDLE.
- LSB-first: MSB_FIRST=0, `word_in`=8'h0D → sequence 1,0,1,1,0,0,0,0. Fed into the 1011 detector, this produces exactly one `pattern_detect` pulse.
- Back-to-back streaming: words 8'h05 then 8'hB0 with `word_valid` held high, no parity → 16 consecutive `bit_valid` cycles with no gap. The detector sees the 1011 that spans the two words.
- Upstream gap: `word_valid` dropped for 3 cycles between words → `bit_valid`=0 for exactly 3 cycles, `busy`=0 during the gap.
- Parity build: `SERIAL_FEEDER_PARITY_EN` defined, `word_in`=8'hB0 → 8 data bits then parity bit 1. Word 8'h03 → parity 0. A second word is accepted only in the PAR cycle.

Source files
------------

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder for bit-stream pattern detectors.
// Optional even-parity bit after each word: define SERIAL_FEEDER_PARITY_EN.
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             d_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_FEEDER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             xfer;
  logic             ready_nxt, d_nxt;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             par, par_nxt;
`endif

  // word_ready is a registered decode of state, so no valid->ready loop
  assign xfer = word_valid && word_ready;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v << 1;
    else                return v >> 1;
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v[WIDTH-1];
    else                return v[0];
  endfunction

  // Next state plus next values of the registered outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    ready_nxt = 1'b0;
    d_nxt     = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          sreg_nxt  = word_in;
`ifdef SERIAL_FEEDER_PARITY_EN
          par_nxt   = ^word_in;
`endif
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          cnt_nxt  = cnt + CW'(1);
          sreg_nxt = shift_one(sreg);
        end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
          state_nxt = PAR;
          cnt_nxt   = '0;
`else
          cnt_nxt = '0;
          if (xfer) begin
            sreg_nxt = word_in;
          end else begin
            state_nxt = IDLE;
          end
`endif
        end
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      PAR: begin
        cnt_nxt = '0;
        if (xfer) begin
          state_nxt = SHIFT;
          sreg_nxt  = word_in;
          par_nxt   = ^word_in;
        end else begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    case (state_nxt)
      IDLE: ready_nxt = 1'b1;
      SHIFT: begin
        d_nxt = head_bit(sreg_nxt);
`ifndef SERIAL_FEEDER_PARITY_EN
        ready_nxt = (cnt_nxt == LAST);
`endif
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      PAR: begin
        ready_nxt = 1'b1;
        d_nxt     = par_nxt;
      end
`endif
      default: ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      word_ready  <= 1'b1;
      d_out       <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sreg        <= sreg_nxt;
      word_ready  <= ready_nxt;
      d_out       <= d_nxt;
      bit_valid   <= (state_nxt != IDLE);
      frame_start <= (state_nxt == SHIFT) && (cnt_nxt == '0);
      busy        <= (state_nxt != IDLE);
`ifdef SERIAL_FEEDER_PARITY_EN
      par         <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: word-slot reference model, MSB- and LSB-first instances.
module tb_serial_word_feeder;

  localparam int unsigned W = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int L  = W + 1;
  localparam bit PE = 1'b1;
`else
  localparam int L  = W;
  localparam bit PE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [W-1:0] word_in = '0;
  logic word_valid = 1'b0;

  logic rdy_m, d_m, bv_m, fs_m, busy_m;
  logic rdy_l, d_l, bv_l, fs_l, busy_l;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(rdy_m), .d_out(d_m), .bit_valid(bv_m), .frame_start(fs_m), .busy(busy_m));

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(rdy_l), .d_out(d_l), .bit_valid(bv_l), .frame_start(fs_l), .busy(busy_l));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word occupies slot positions 0..L-1; -1 means no word.
  int pos = -1;
  logic [W-1:0] mword = '0;
  bit mxfer;

  function automatic bit m_ready();
    return (pos < 0) || (pos == L - 1);
  endfunction

  function automatic logic m_bit(input bit msb);
    if (pos >= int'(W)) return ^mword;
    if (msb) return mword[W-1-pos];
    return mword[pos];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos = -1;
    end else begin
      mxfer = word_valid && m_ready();
      if (m_ready()) begin
        if (mxfer) begin
          mword = word_in;
          pos = 0;
        end else begin
          pos = -1;
        end
      end else begin
        pos++;
      end
    end
  end

  task automatic check_all();
    bit act;
    act = (pos >= 0);
    chk("ready_msb", rdy_m, m_ready());
    chk("valid_msb", bv_m, act);
    chk("busy_msb", busy_m, act);
    chk("fstart_msb", fs_m, pos == 0);
    chk("dout_msb", d_m, act ? m_bit(1'b1) : 1'b0);
    chk("ready_lsb", rdy_l, m_ready());
    chk("valid_lsb", bv_l, act);
    chk("busy_lsb", busy_l, act);
    chk("fstart_lsb", fs_l, pos == 0);
    chk("dout_lsb", d_l, act ? m_bit(1'b0) : 1'b0);
  endtask

  // Serial streams as seen by a detector, oldest bit in the highest used position
  logic [31:0] col_m = '0, col_l = '0;
  int nb_m = 0, nb_l = 0;
  int gap_run = 0, last_gap = -1;

  always @(negedge clk) begin
    check_all();
    if (bv_m) begin
      col_m = {col_m[30:0], d_m};
      nb_m++;
      if (gap_run > 0) last_gap = gap_run;
      gap_run = 0;
    end else begin
      gap_run++;
    end
    if (bv_l) begin
      col_l = {col_l[30:0], d_l};
      nb_l++;
    end
  end

  task automatic clear_cols();
    #1;
    col_m = '0; col_l = '0; nb_m = 0; nb_l = 0;
    gap_run = 0; last_gap = -1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int n;
    n = 0;
    word_in = w;
    word_valid = 1'b1;
    while (!m_ready() && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    word_valid = 1'b0;
  endtask

  function automatic int count_1011(input logic [31:0] s, input int n);
    int c;
    c = 0;
    for (int i = n - 1; i >= 3; i--)
      if (s[i] && !s[i-1] && s[i-2] && s[i-3]) c++;
    return c;
  endfunction

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", rdy_m, 1'b1);
    chk("reset_valid", bv_m, 1'b0);
    chk("reset_busy", busy_l, 1'b0);
    #1 rst = 1'b1;

    // MSB-first single word
    clear_cols();
    send(8'hB0);
    repeat (L + 1) @(negedge clk);
    #1;
    chk("msb_B0_stream", col_m, PE ? 32'h161 : 32'hB0);
    chk("msb_B0_bits", 32'(nb_m), 32'(L));

    // LSB-first: 0D serialises as 1011_0000
    clear_cols();
    send(8'h0D);
    repeat (L + 1) @(negedge clk);
    #1;
    chk("lsb_0D_stream", col_l, PE ? 32'h161 : 32'hB0);
    chk("lsb_0D_detect", 32'(count_1011(col_l, nb_l)), 32'd1);

    // Parity-zero word
    clear_cols();
    send(8'h03);
    repeat (L + 1) @(negedge clk);
    #1;
    chk("msb_03_stream", col_m, PE ? 32'h006 : 32'h03);

    // Back-to-back words, pattern spans the boundary
    clear_cols();
    send(8'h05);
    send(8'hB0);
    repeat (L + 2) @(negedge clk);
    #1;
    chk("b2b_stream", col_m, PE ? 32'h1561 : 32'h05B0);
    chk("b2b_bits", 32'(nb_m), 32'(2 * L));
    chk("b2b_detect", 32'(count_1011(col_m, nb_m)), PE ? 32'd1 : 32'd2);

    // Three-cycle upstream gap
    clear_cols();
    send(8'h5A);
    repeat (L + 2) @(posedge clk);
    #1;
    send(8'hC3);
    repeat (L + 2) @(negedge clk);
    #1;
    chk("gap_len", 32'(last_gap), 32'd3);

    // Asynchronous reset mid-word
    send(8'hFF);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_valid_msb", bv_m, 1'b0);
    chk("midrst_valid_lsb", bv_l, 1'b0);
    chk("midrst_busy", busy_m, 1'b0);
    chk("midrst_ready", rdy_m, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;

    // Randomised traffic against the model
    repeat (400) begin
      @(posedge clk); #1;
      word_valid = ($urandom_range(0, 3) != 0);
      word_in = W'($urandom);
    end
    word_valid = 1'b0;
    repeat (L + 3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
